// File: rtl/circle_pkg.sv
// Shared types and constants for the 160x120 circle-drawing datapath.
package circle_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int SEL_POS_A = 0;
  localparam int SEL_POS_B = 1;
  localparam int SEL_NEG_A = 2;
  localparam int SEL_NEG_B = 3;
  localparam int SEL_CNT   = 4;

  typedef logic [2:0]        colour_t;
  typedef logic signed [8:0] coord_t;

  function automatic logic onehot5(input logic [4:0] s);
    return (s != 5'd0) && ((s & (s - 5'd1)) == 5'd0);
  endfunction

endpackage

// File: rtl/circle_octant_mux.sv
// One-axis coordinate select: centre +/- offset or the clear counter.
module circle_octant_mux
  import circle_pkg::*;
(
  input  coord_t     centre,
  input  coord_t     pos_a,
  input  coord_t     pos_b,
  input  coord_t     cnt,
  input  logic [4:0] sel,
  output coord_t     coord,
  output logic       valid
);

  always_comb begin
    coord = '0;
    valid = onehot5(sel);
    if (valid) begin
      unique case (1'b1)
        sel[SEL_POS_A]: coord = centre + pos_a;
        sel[SEL_POS_B]: coord = centre + pos_b;
        sel[SEL_NEG_A]: coord = centre - pos_a;
        sel[SEL_NEG_B]: coord = centre - pos_b;
        sel[SEL_CNT]:   coord = cnt;
      endcase
    end
  end

endmodule

// File: rtl/circle_datapath.sv
// Clear counters, Bresenham circle registers and registered VGA pixel port.
// Optional CIRCLE_CLIP_EN suppresses plots of off-screen coordinates.
module circle_datapath
  import circle_pkg::*;
#(
  parameter int      CENTRE_X    = 80,
  parameter int      CENTRE_Y    = 60,
  parameter int      RADIUS      = 40,
  parameter colour_t DRAW_COLOUR = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       initx,
  input  logic       loadx,
  input  logic       inity,
  input  logic       loady,
  input  logic       initc,
  input  logic       loadc,
  input  logic       flagc,
  input  logic       plot,
  input  logic [4:0] selx,
  input  logic [4:0] sely,
  output logic       xdone,
  output logic       ydone,
  output logic       cdone,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output colour_t    vga_colour,
  output logic       vga_plot
);

  localparam coord_t CX = coord_t'(CENTRE_X);
  localparam coord_t CY = coord_t'(CENTRE_Y);
  localparam coord_t R  = coord_t'(RADIUS);

  logic [7:0] xcnt;
  logic [6:0] ycnt;
  coord_t     ox, oy, crit;
  coord_t     ox_n, oy_n, crit_n;
  coord_t     xc, yc;
  logic       xv, yv, onscreen;

  assign xdone = (xcnt == 8'd159);
  assign ydone = (ycnt == 7'd119);
  assign cdone = (oy > ox);

  // One Bresenham step, all terms from pre-step values.
  always_comb begin
    oy_n = oy + 9'sd1;
    ox_n = ox;
    crit_n = crit + (oy_n <<< 1) + 9'sd1;
    if (crit > 9'sd0) begin
      ox_n = ox - 9'sd1;
      crit_n = crit + ((oy_n - ox_n) <<< 1) + 9'sd1;
    end
  end

  circle_octant_mux u_mux_x (
    .centre(CX),
    .pos_a (ox),
    .pos_b (oy),
    .cnt   ({1'b0, xcnt}),
    .sel   (selx),
    .coord (xc),
    .valid (xv)
  );

  circle_octant_mux u_mux_y (
    .centre(CY),
    .pos_a (oy),
    .pos_b (ox),
    .cnt   ({2'b00, ycnt}),
    .sel   (sely),
    .coord (yc),
    .valid (yv)
  );

`ifdef CIRCLE_CLIP_EN
  assign onscreen = (xc >= 9'sd0) && (xc < coord_t'(SCREEN_W))
                 && (yc >= 9'sd0) && (yc < coord_t'(SCREEN_H));
`else
  logic unused_hi;
  assign unused_hi = ^{xc[8], yc[8:7]};
  assign onscreen  = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xcnt       <= '0;
      ycnt       <= '0;
      ox         <= '0;
      oy         <= '0;
      crit       <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
    end else begin
      if (initx)      xcnt <= '0;
      else if (loadx) xcnt <= xdone ? 8'd0 : xcnt + 8'd1;
      if (inity)      ycnt <= '0;
      else if (loady) ycnt <= ydone ? 7'd0 : ycnt + 7'd1;
      if (initc) begin
        ox   <= R;
        oy   <= '0;
        crit <= 9'sd1 - R;
      end else if (loadc) begin
        ox   <= ox_n;
        oy   <= oy_n;
        crit <= crit_n;
      end
      vga_x      <= xc[7:0];
      vga_y      <= yc[6:0];
      vga_colour <= flagc ? DRAW_COLOUR : colour_t'(3'b000);
      vga_plot   <= plot & xv & yv & onscreen;
    end
  end

endmodule

// File: tb/tb_circle_datapath.sv
// Randomised and directed bench for circle_datapath against an integer model.
module tb_circle_datapath;

  localparam int CX = 80;
  localparam int CY = 60;
  localparam int R  = 40;

  logic       clk = 0;
  logic       reset;
  logic       initx, loadx, inity, loady, initc, loadc, flagc, plot;
  logic [4:0] selx, sely;

  logic       xdone, ydone, cdone, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  logic       xdone_l, ydone_l, cdone_l, plot_l;
  logic [7:0] x_l;
  logic [6:0] y_l;
  logic [2:0] col_l;

  logic       xdone_z, ydone_z, cdone_z, plot_z;
  logic [7:0] x_z;
  logic [6:0] y_z;
  logic [2:0] col_z;

  always #5 clk = ~clk;

  circle_datapath dut (
    .clk(clk), .reset(reset),
    .initx(initx), .loadx(loadx), .inity(inity), .loady(loady),
    .initc(initc), .loadc(loadc), .flagc(flagc), .plot(plot),
    .selx(selx), .sely(sely),
    .xdone(xdone), .ydone(ydone), .cdone(cdone),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot)
  );

  circle_datapath #(.CENTRE_X(10)) dut_l (
    .clk(clk), .reset(reset),
    .initx(initx), .loadx(loadx), .inity(inity), .loady(loady),
    .initc(initc), .loadc(loadc), .flagc(flagc), .plot(plot),
    .selx(selx), .sely(sely),
    .xdone(xdone_l), .ydone(ydone_l), .cdone(cdone_l),
    .vga_x(x_l), .vga_y(y_l), .vga_colour(col_l),
    .vga_plot(plot_l)
  );

  circle_datapath #(.RADIUS(0)) dut_z (
    .clk(clk), .reset(reset),
    .initx(initx), .loadx(loadx), .inity(inity), .loady(loady),
    .initc(initc), .loadc(loadc), .flagc(flagc), .plot(plot),
    .selx(selx), .sely(sely),
    .xdone(xdone_z), .ydone(ydone_z), .cdone(cdone_z),
    .vga_x(x_z), .vga_y(y_z), .vga_colour(col_z),
    .vga_plot(plot_z)
  );

  int n_chk = 0;
  int n_pass = 0;

  // behavioural model state
  int mx, my, mox, moy, mcrit;
  int e_x, e_y, e_col;
  bit e_plot;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int mcoord(input logic [4:0] s, input int c,
                                input int a, input int b, input int cnt);
    case (s)
      5'b00001: return c + a;
      5'b00010: return c + b;
      5'b00100: return c - a;
      5'b01000: return c - b;
      5'b10000: return cnt;
      default:  return 0;
    endcase
  endfunction

  task automatic idle();
    {initx, loadx, inity, loady, initc, loadc, flagc, plot} = '0;
    selx = '0;
    sely = '0;
  endtask

  task automatic model_reset();
    mx = 0; my = 0; mox = 0; moy = 0; mcrit = 0;
  endtask

  // Predict outputs from pre-edge state, advance model, wait one cycle.
  task automatic tick();
    int xc, yc, oy1;
    bit on;
    xc = mcoord(selx, CX, mox, moy, mx);
    yc = mcoord(sely, CY, moy, mox, my);
`ifdef CIRCLE_CLIP_EN
    on = xc >= 0 && xc < 160 && yc >= 0 && yc < 120;
`else
    on = 1;
`endif
    e_x = xc & 255;
    e_y = yc & 127;
    e_col = flagc ? 2 : 0;
    e_plot = plot && $countones(selx) == 1 && $countones(sely) == 1 && on;
    if (initx) mx = 0;
    else if (loadx) mx = (mx + 1) % 160;
    if (inity) my = 0;
    else if (loady) my = (my + 1) % 120;
    if (initc) begin
      mox = R; moy = 0; mcrit = 1 - R;
    end else if (loadc) begin
      oy1 = moy + 1;
      if (mcrit <= 0) mcrit = mcrit + 2 * oy1 + 1;
      else begin
        mox = mox - 1;
        mcrit = mcrit + 2 * (oy1 - mox) + 1;
      end
      moy = oy1;
    end
    @(negedge clk);
  endtask

  task automatic chk_all(input string tag);
    check({tag, ".x"}, vga_x, e_x);
    check({tag, ".y"}, vga_y, e_y);
    check({tag, ".col"}, vga_colour, e_col);
    check({tag, ".plot"}, vga_plot, e_plot);
    check({tag, ".xdone"}, xdone, mx == 159);
    check({tag, ".ydone"}, ydone, my == 119);
    check({tag, ".cdone"}, cdone, moy > mox);
  endtask

  function automatic logic [4:0] rsel();
    if ($urandom_range(0, 3) != 0) return 5'd1 << $urandom_range(0, 4);
    return 5'($urandom);
  endfunction

  int cov[160][120];

  initial begin
    int n, cov_err, col_err, yerr, yseen;
    idle();
    model_reset();
    reset = 1;
    @(negedge clk);
    reset = 0;
    check("rst.x", vga_x, 0);
    check("rst.y", vga_y, 0);
    check("rst.col", vga_colour, 0);
    check("rst.plot", vga_plot, 0);
    check("rst.xdone", xdone, 0);
    check("rst.ydone", ydone, 0);
    check("rst.cdone", cdone, 0);

    // 159 plotted X increments
    initx = 1; inity = 1; tick(); idle();
    for (int i = 0; i < 159; i++) begin
      loadx = 1; plot = 1; selx = 5'b10000; sely = 5'b10000;
      tick();
    end
    check("xrun.xdone", xdone, 1);
    check("xrun.vga_x", vga_x, 158);
    check("xrun.plot", vga_plot, 1);
    idle(); loadx = 1; tick(); idle();
    check("xwrap.xdone", xdone, 0);
    chk_all("xwrap");

    // full clear sweep
    initx = 1; inity = 1; tick(); idle();
    foreach (cov[i, j]) cov[i][j] = 0;
    cov_err = 0; col_err = 0; yerr = 0; yseen = 0;
    for (int i = 0; i < 19200; i++) begin
      loadx = 1; loady = (mx == 159); plot = 1;
      selx = 5'b10000; sely = 5'b10000; flagc = 0;
      tick();
      if (vga_plot) begin
        if (vga_x < 160 && vga_y < 120) cov[vga_x][vga_y]++;
        else cov_err++;
        if (vga_colour != 0) col_err++;
      end
      if (ydone !== (my == 119)) yerr++;
      if (ydone === 1'b1) yseen++;
    end
    idle();
    foreach (cov[i, j]) if (cov[i][j] != 1) cov_err++;
    check("sweep.cover", cov_err, 0);
    check("sweep.colour", col_err, 0);
    check("sweep.ydone", yerr, 0);
    check("sweep.ydone_cycles", yseen, 160);

    // circle init and first step
    initc = 1; tick(); idle();
    check("r0.init_cdone", cdone_z, 0);
    plot = 1; selx = 5'b00100; sely = 5'b00001; flagc = 1;
    tick(); idle();
    chk_all("negx");
`ifdef CIRCLE_CLIP_EN
    check("clip.plot", plot_l, 0);
`else
    check("wrap.plot", plot_l, 1);
    check("wrap.x", x_l, 226);
`endif
    loadc = 1; tick(); idle();
    check("r0.step_cdone", cdone_z, 1);
    plot = 1; selx = 5'b00001; sely = 5'b00001; flagc = 1;
    tick(); idle();
    check("step1.x", vga_x, 120);
    check("step1.y", vga_y, 61);
    check("step1.col", vga_colour, 3'b010);
    check("step1.plot", vga_plot, 1);
    plot = 1; selx = 5'b00011; sely = 5'b00001;
    tick(); idle();
    check("multihot.plot", vga_plot, 0);

    // Bresenham run to cdone
    initc = 1; tick(); idle();
    n = 0;
    while (!(moy > mox) && n < 100) begin
      loadc = 1; tick(); idle();
      plot = 1; selx = 5'b00001; sely = 5'b00001; flagc = 1;
      tick(); idle();
      chk_all("step");
      n++;
    end
    check("step.bound", n < 100, 1);
    check("end.cdone", cdone, 1);
    check("end.x", vga_x, CX + 28);
    check("end.y", vga_y, CY + 29);

    // reset mid-circle
    initc = 1; tick(); idle();
    loadc = 1; tick(); tick(); idle();
    plot = 1; selx = 5'b00001; sely = 5'b00001; flagc = 1; tick();
    idle();
    reset = 1;
    @(negedge clk);
    reset = 0;
    model_reset();
    check("mrst.x", vga_x, 0);
    check("mrst.y", vga_y, 0);
    check("mrst.col", vga_colour, 0);
    check("mrst.plot", vga_plot, 0);
    check("mrst.cdone", cdone, 0);
    plot = 1; selx = 5'b00001; sely = 5'b00010; tick(); idle();
    check("mrst.regs_x", vga_x, CX);
    check("mrst.regs_y", vga_y, CY);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      initx = ($urandom_range(0, 31) == 0);
      loadx = $urandom_range(0, 1);
      inity = ($urandom_range(0, 31) == 0);
      loady = $urandom_range(0, 1);
      initc = ($urandom_range(0, 15) == 0);
      loadc = !(moy > mox) && $urandom_range(0, 1);
      flagc = $urandom_range(0, 1);
      plot = $urandom_range(0, 1);
      selx = rsel();
      sely = rsel();
      tick();
      chk_all("rand");
    end
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
